// File: rtl/mult_datapath.sv
// Shift-add datapath of the WxW unsigned multiplier: operand A, partial product P, shift counter.
// Optional sticky sequencing check enabled by defining MULT_DP_SEQCHK_EN.
module mult_datapath #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   a_in,
   input  logic [W-1:0]   b_in,
   input  logic           sig_rst,
   input  logic           ld1,
   input  logic           ld2,
   input  logic           s0,
   input  logic           s1,
   input  logic           s2,
   output logic [2*W-1:0] product,
   output logic           done,
   output logic           cnt_full,
   output logic           seq_err
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(W);

   logic [W-1:0]   a_reg, a_next;
   logic [2*W:0]   p_reg, p_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic [2*W-1:0] product_reg, product_next;
   logic           done_reg, done_next;
   logic [W:0]     sum;
   logic [2*W:0]   p_added;
   logic           load;

   assign load = ld1 | ld2;
   assign sum  = {1'b0, p_reg[2*W-1:W]} + {1'b0, a_reg};

   // Combined s0+s1 cycles shift the post-add value, matching two separate cycles.
   always_comb begin
      p_added = p_reg;
      if (s0 && p_reg[0])
         p_added = {sum, p_reg[W-1:0]};
   end

   always_comb begin
      a_next       = a_reg;
      p_next       = p_reg;
      cnt_next     = cnt_reg;
      product_next = product_reg;
      done_next    = 1'b0;
      if (sig_rst) begin
         a_next   = '0;
         p_next   = '0;
         cnt_next = '0;
      end else begin
         if (load) begin
            if (ld1)
               a_next = a_in;
            if (ld2) begin
               p_next   = {{(W+1){1'b0}}, b_in};
               cnt_next = '0;
            end
         end else if (s1) begin
            p_next = p_added >> 1;
            if (cnt_reg != CNT_MAX)
               cnt_next = cnt_reg + CW'(1);
         end else begin
            p_next = p_added;
         end
         // Result latch sees P as it stood before this cycle's update.
         if (s2) begin
            product_next = p_reg[2*W-1:0];
            done_next    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg       <= '0;
         p_reg       <= '0;
         cnt_reg     <= '0;
         product_reg <= '0;
         done_reg    <= 1'b0;
      end else begin
         a_reg       <= a_next;
         p_reg       <= p_next;
         cnt_reg     <= cnt_next;
         product_reg <= product_next;
         done_reg    <= done_next;
      end
   end

`ifdef MULT_DP_SEQCHK_EN
   logic seq_err_reg, seq_err_next;

   always_comb begin
      seq_err_next = seq_err_reg;
      if (!sig_rst) begin
         if (s2 && (cnt_reg != CNT_MAX))
            seq_err_next = 1'b1;
         if (s1 && !load && (cnt_reg == CNT_MAX))
            seq_err_next = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         seq_err_reg <= 1'b0;
      else
         seq_err_reg <= seq_err_next;
   end

   assign seq_err = seq_err_reg;
`else
   assign seq_err = 1'b0;
`endif

   assign product  = product_reg;
   assign done     = done_reg;
   assign cnt_full = (cnt_reg == CNT_MAX);

endmodule
